// File: rtl/seq_detector.sv
// Serial bit-pattern detector: overlapping Mealy FSM that flags y while the
// current x completes PATTERN (bit PAT_LEN-1 arrives first in time).
// The next-state table is derived from PATTERN at elaboration using the KMP
// failure function, so any pattern of length 2..16 works without edits.
// Optional feature macro: SEQ_DET_COUNT_EN adds a saturating match_count output.
module seq_detector #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110
`ifdef SEQ_DET_COUNT_EN
  ,
  parameter int unsigned        COUNT_W = 8
`endif
) (
  input  logic               x,
  input  logic               clk,
  input  logic               reset,
  output logic               y
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [COUNT_W-1:0] match_count
`endif
);

  localparam int unsigned SW       = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned NumSlots = 2 ** SW;
  localparam int unsigned TW       = NumSlots * 2 * SW;

  localparam logic [SW-1:0] LastState = SW'(PAT_LEN - 1);

  // Entry (k*2 + b) holds the next state from Sk on input bit b. Unreachable
  // encodings (k >= PAT_LEN) fall back to S0.
  function automatic logic [TW-1:0] build_trans();
    logic [TW-1:0] tbl;
    int            best;
    int            idx;
    logic          ok;
    logic          sb;
    tbl = '0;
    for (int k = 0; k < int'(PAT_LEN); k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        // Longest proper pattern prefix that is a suffix of (prefix_k + b).
        for (int j = 1; j < int'(PAT_LEN); j++) begin
          if (j <= k + 1) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
              idx = k + 1 - j + t;
              sb  = (idx == k) ? b[0] : PATTERN[int'(PAT_LEN) - 1 - idx];
              if (sb != PATTERN[int'(PAT_LEN) - 1 - t]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        tbl[(k * 2 + b) * int'(SW) +: SW] = SW'(best);
      end
    end
    return tbl;
  endfunction

  localparam logic [TW-1:0] TransTbl = build_trans();

  logic [SW-1:0] state_q, state_d;
  logic [SW:0]   slot;

  // State register: async clear to S0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state lookup and Mealy output.
  always_comb begin
    slot    = {state_q, x};
    state_d = TransTbl[int'(slot) * int'(SW) +: SW];
    y       = reset && (state_q == LastState) && (x == PATTERN[0]);
  end

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  // Saturating increment on every detecting edge.
  always_comb begin
    count_d = count_q;
    if (y && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register: async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: a shift-history reference model predicts y
// for the default "0110" detector and a "111" detector sharing the stream;
// predictions queue up as bits are driven and are checked mid-cycle.
module tb_seq_detector;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic y;
  logic y3;

  int errors = 0;
  int checks = 0;

  logic q_y[$];
  logic q_y3[$];

  // Reference model: recent bits and how many were received since reset.
  logic [15:0] hist;
  int          valid;
  int          cnt_m;

  always #5 clk = ~clk;

`ifdef SEQ_DET_COUNT_EN
  logic [1:0] cnt;
  logic [7:0] cnt3;

  seq_detector #(.PAT_LEN(4), .PATTERN(4'b0110), .COUNT_W(2)) dut (
    .x(x), .clk(clk), .reset(reset), .y(y), .match_count(cnt)
  );
  seq_detector #(.PAT_LEN(3), .PATTERN(3'b111)) dut3 (
    .x(x), .clk(clk), .reset(reset), .y(y3), .match_count(cnt3)
  );
`else
  seq_detector #(.PAT_LEN(4), .PATTERN(4'b0110)) dut (
    .x(x), .clk(clk), .reset(reset), .y(y)
  );
  seq_detector #(.PAT_LEN(3), .PATTERN(3'b111)) dut3 (
    .x(x), .clk(clk), .reset(reset), .y(y3)
  );
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_reset(input logic r);
    reset = r;
    if (!r) begin
      hist  = '0;
      valid = 0;
      cnt_m = 0;
    end
  endtask

  // Drive one bit just after a rising edge, check at the falling edge, then
  // advance the model across the next rising edge.
  task automatic step(input logic b);
    logic e4;
    logic e3;
    x  = b;
    e4 = reset && (valid >= 3) && ({hist[2:0], b} == 4'b0110);
    e3 = reset && (valid >= 2) && ({hist[1:0], b} == 3'b111);
    q_y.push_back(e4);
    q_y3.push_back(e3);
    @(negedge clk);
    check("y_0110", {7'd0, y}, {7'd0, q_y.pop_front()});
    check("y_111", {7'd0, y3}, {7'd0, q_y3.pop_front()});
`ifdef SEQ_DET_COUNT_EN
    check("match_count", {6'd0, cnt}, 8'(cnt_m));
`endif
    @(posedge clk);
    if (reset) begin
      hist  = {hist[14:0], b};
      valid++;
      if (e4 && cnt_m < 3) cnt_m++;
    end
    #1;
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i]);
  endtask

  initial begin
    x = 1'b0;
    set_reset(1'b0);
    @(posedge clk);
    #1;

    // Reset held with x toggling: y must stay low.
    step(1'b1);
    step(1'b0);
    step(1'b1);
    set_reset(1'b1);

    // Main stream, first bit 0 goes to S1 silently; pulses on bits 5, 8, 12.
    run_bits(32'b0011_0110_0110, 12);

    // Near misses from a clean start.
    set_reset(1'b0);
    step(1'b0);
    set_reset(1'b1);
    run_bits(32'b0101110, 7);

    // Partial progress then a reset pulse mid-cycle while x completes the pattern.
    set_reset(1'b0);
    step(1'b0);
    set_reset(1'b1);
    run_bits(32'b011, 3);
    x = 1'b0;
    #1;
    set_reset(1'b0);
    #2;
    check("y_in_reset", {7'd0, y}, 8'd0);
    @(posedge clk);
    #1;
    step(1'b0);
    set_reset(1'b1);
    run_bits(32'b0110, 4);

    // All-ones stream: the 111 detector fires on bits 3, 4, 5.
    set_reset(1'b0);
    step(1'b0);
    set_reset(1'b1);
    run_bits(32'b11111, 5);

    // Five overlapping 0110 matches; a 2-bit counter saturates at 3.
    set_reset(1'b0);
    step(1'b0);
    set_reset(1'b1);
    run_bits(32'b0110_1101_1011_0110, 16);
    step(1'b1);
    set_reset(1'b0);
    step(1'b0);
    set_reset(1'b1);
    step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
